// File: rtl/im_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package im_loader_pkg;

  typedef enum logic [2:0] {
    CNT_HI,
    CNT_LO,
    DATA,
    WRITE,
    CHK,
    DONE,
    ERR
  } ldr_state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/im_loader_asm.sv
// Byte-to-word assembler: shifts bytes in MSB first and flags the byte that completes a word.
module im_loader_asm
  import im_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_ready_o
);

  logic [1:0]  cnt_q;
  logic [31:0] sr_q;

  // word_o already includes the byte being accepted, so the top can register it on word_ready_o.
  assign word_o       = {sr_q[23:0], byte_i};
  assign word_ready_o = shift_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else if (shift_i) begin
      cnt_q <= cnt_q + 2'd1;
      sr_q  <= word_o;
    end
  end

endmodule

// File: rtl/im_loader.sv
// Program loader: parses a counted big-endian byte stream and writes words into instruction memory.
// Optional trailing XOR checksum byte enabled by defining IM_LOADER_CHECKSUM_EN.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int NMEM = 20,
  parameter int AW   = $clog2(NMEM)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  output logic          im_we,
  output logic [AW-1:0] im_waddr,
  output logic [31:0]   im_wdata,
  output logic          cpu_run,
  output logic          done,
  output logic          err
);

  ldr_state_t    state_q, state_d;
  logic [7:0]    cnt_hi_q, cnt_hi_d;
  logic [15:0]   n_q, n_d;
  logic [AW-1:0] widx_q, widx_d;
  logic          im_we_q;
  logic [AW-1:0] im_waddr_q;
  logic [31:0]   im_wdata_q;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0]    chk_q, chk_d;
`endif

  logic          xfer;
  logic [15:0]   n_rx;
  logic          asm_clr, asm_shift, word_ready;
  logic [31:0]   asm_word;

  assign xfer = in_valid && in_ready;
  assign n_rx = {cnt_hi_q, in_data};

  im_loader_asm u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (asm_clr),
    .shift_i      (asm_shift),
    .byte_i       (in_data),
    .word_o       (asm_word),
    .word_ready_o (word_ready)
  );

  always_comb begin
    state_d   = state_q;
    cnt_hi_d  = cnt_hi_q;
    n_d       = n_q;
    widx_d    = widx_q;
    in_ready  = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    cpu_run   = 1'b0;
    asm_clr   = 1'b0;
    asm_shift = 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
    chk_d     = chk_q;
`endif
    case (state_q)
      CNT_HI: begin
        in_ready = 1'b1;
        if (xfer) begin
          cnt_hi_d = in_data;
          state_d  = CNT_LO;
        end
      end
      CNT_LO: begin
        in_ready = 1'b1;
        if (xfer) begin
          n_d = n_rx;
          if (n_rx == 16'd0) begin
`ifdef IM_LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = DONE;
`endif
          end else if (n_rx > 16'(NMEM)) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (xfer) begin
          asm_shift = 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
          chk_d = chk_q ^ in_data;
`endif
          if (word_ready) state_d = WRITE;
        end
      end
      WRITE: begin
        widx_d = widx_q + 1'b1;
        if (16'(widx_q) == n_q - 16'd1) begin
`ifdef IM_LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = DATA;
        end
      end
`ifdef IM_LOADER_CHECKSUM_EN
      CHK: begin
        in_ready = 1'b1;
        if (xfer) state_d = (in_data == chk_q) ? DONE : ERR;
      end
`endif
      DONE: begin
        done    = 1'b1;
        cpu_run = 1'b1;
      end
      ERR: begin
        err = 1'b1;
      end
      default: state_d = CNT_HI;
    endcase

    // A restart wipes all per-load bookkeeping so the next image starts at word 0.
    if ((state_q == DONE || state_q == ERR) && start) begin
      state_d  = CNT_HI;
      cnt_hi_d = '0;
      n_d      = '0;
      widx_d   = '0;
      asm_clr  = 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
      chk_d    = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CNT_HI;
      cnt_hi_q   <= '0;
      n_q        <= '0;
      widx_q     <= '0;
      im_we_q    <= 1'b0;
      im_waddr_q <= '0;
      im_wdata_q <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_hi_q <= cnt_hi_d;
      n_q      <= n_d;
      widx_q   <= widx_d;
      im_we_q  <= (state_d == WRITE);
      if (word_ready) begin
        im_waddr_q <= widx_q;
        im_wdata_q <= asm_word;
      end
`ifdef IM_LOADER_CHECKSUM_EN
      chk_q <= chk_d;
`endif
    end
  end

  assign im_we    = im_we_q;
  assign im_waddr = im_waddr_q;
  assign im_wdata = im_wdata_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed plus randomized bench for im_loader against a stream-level reference model.
module tb_im_loader;

  localparam int NMEM = 20;
  localparam int AW   = $clog2(NMEM);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          im_we;
  logic [AW-1:0] im_waddr;
  logic [31:0]   im_wdata;
  logic          cpu_run;
  logic          done;
  logic          err;

  im_loader #(.NMEM(NMEM), .AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .im_we    (im_we),
    .im_waddr (im_waddr),
    .im_wdata (im_wdata),
    .cpu_run  (cpu_run),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Observed memory writes, collected away from the active edge.
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  int            wc_q[$];
  int            viol = 0;
  int            done_cyc = -1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (im_we) begin
        wa_q.push_back(im_waddr);
        wd_q.push_back(im_wdata);
        wc_q.push_back(cyc);
        if (in_ready) viol++;
      end
      if ((done || err) && done_cyc < 0) done_cyc = cyc;
    end
  end

  logic [7:0] dq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output int acc);
    int budget;
    bit got;
    acc = -1;
    if (gap == 1) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end else if (gap == 2) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_data  = b;
    budget = 0;
    got = 1'b0;
    while (!got && budget < 50) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        acc = cyc;
        got = 1'b1;
      end
      budget++;
    end
    if (!got) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout: observed in_ready=0 for 50 cycles expected byte %0h taken", b);
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Sends count + payload (+ checksum when enabled) and compares against the stream model.
  task automatic run_load(input int n, input int gap, input bit bad_chk, input string tag);
    logic [7:0]  s[$];
    logic [7:0]  x;
    int          wr_end[$];
    int          acc, exp_done, exp_nwr, b;
    bit          over, exp_err;
    logic [31:0] w;
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    viol = 0;
    done_cyc = -1;
    over = (n > NMEM);
    exp_err = over;
    exp_nwr = over ? 0 : n;
    s.push_back(n[15:8]);
    s.push_back(n[7:0]);
    x = 8'h00;
    if (!over) begin
      for (int i = 0; i < 4 * n; i++) begin
        s.push_back(dq[i]);
        x ^= dq[i];
      end
    end
`ifdef IM_LOADER_CHECKSUM_EN
    if (!over) begin
      s.push_back(bad_chk ? (x ^ 8'h01) : x);
      if (bad_chk) exp_err = 1'b1;
    end
`endif
    exp_done = -1;
    for (int k = 0; k < s.size(); k++) begin
      send_byte(s[k], gap, acc);
      exp_done = acc;
      if (!over && k >= 2 && k < 2 + 4 * n && ((k - 2) % 4) == 3) wr_end.push_back(acc);
    end
`ifndef IM_LOADER_CHECKSUM_EN
    if (!over && n > 0) exp_done = wr_end[n-1] + 1;
`endif
    b = 0;
    while (!(done || err) && b < 30) begin
      @(negedge clk);
      b++;
    end
    repeat (2) @(negedge clk);
    check({tag, ".nwrites"}, wa_q.size(), exp_nwr);
    for (int i = 0; i < exp_nwr && i < wa_q.size(); i++) begin
      w = {dq[4*i], dq[4*i+1], dq[4*i+2], dq[4*i+3]};
      check($sformatf("%s.addr%0d", tag, i), wa_q[i], i);
      check($sformatf("%s.data%0d", tag, i), wd_q[i], w);
      check($sformatf("%s.lat%0d", tag, i), wc_q[i], wr_end[i]);
    end
    check({tag, ".done"}, done, !exp_err);
    check({tag, ".err"}, err, exp_err);
    check({tag, ".cpu_run"}, cpu_run, !exp_err);
    check({tag, ".in_ready_idle"}, in_ready, 1'b0);
    check({tag, ".ready_in_write"}, viol, 0);
    check({tag, ".status_cycle"}, done_cyc, exp_done);
  endtask

  initial begin
    #3_000_000;
    $error("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int n;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst.im_we", im_we, 1'b0);
    check("rst.im_waddr", im_waddr, '0);
    check("rst.im_wdata", im_wdata, 32'h0);
    check("rst.done", done, 1'b0);
    check("rst.err", err, 1'b0);
    check("rst.cpu_run", cpu_run, 1'b0);
    check("rst.in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    dq = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h10};
    run_load(2, 0, 1'b0, "two_word");
    check("two_word.lit0", wd_q[0], 32'h20080005);
    check("two_word.lit1", wd_q[1], 32'hAC080010);

    pulse_start();
    run_load(0, 0, 1'b0, "zero");

    pulse_start();
    run_load(21, 0, 1'b0, "over");
    pulse_start();
    dq = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load(1, 0, 1'b0, "after_err");

    pulse_start();
    dq = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h10};
    run_load(2, 1, 1'b0, "toggle");

    pulse_start();
    send_byte(8'h00, 0, acc);
    send_byte(8'h02, 0, acc);
    send_byte(8'h20, 0, acc);
    send_byte(8'h08, 0, acc);
    send_byte(8'h00, 0, acc);
    send_byte(8'h05, 0, acc);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.im_we", im_we, 1'b0);
    check("midrst.im_wdata", im_wdata, 32'h0);
    check("midrst.cpu_run", cpu_run, 1'b0);
    check("midrst.done", done, 1'b0);
    check("midrst.in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_load(1, 0, 1'b0, "post_rst");

    pulse_start();
    dq.delete();
    for (int i = 0; i < 4 * NMEM; i++) dq.push_back(8'($urandom));
    run_load(NMEM, 2, 1'b0, "full");

    for (int t = 0; t < 5; t++) begin
      pulse_start();
      n = $urandom_range(0, NMEM + 3);
      dq.delete();
      for (int i = 0; i < 4 * NMEM; i++) dq.push_back(8'($urandom));
      run_load(n, $urandom_range(0, 2), 1'b0, $sformatf("rand%0d", t));
    end

`ifdef IM_LOADER_CHECKSUM_EN
    pulse_start();
    dq = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load(1, 0, 1'b0, "chk_ok");
    pulse_start();
    run_load(1, 0, 1'b1, "chk_bad");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Program loader that writes instruction memory, acting as the writer side of the fetch path.
- Accepts a byte stream from the host / co-emulation transactor over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes the words sequentially into instruction memory starting at word 0.
- Holds the CPU out of execution (cpu_run low) until the image is fully written.

Parameters:
- NMEM, 20, instruction memory depth in 32-bit words.
- AW, $clog2(NMEM), width of the word address.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse; restarts a load from DONE or ERR
- in_valid  input  1  stream byte valid
- in_ready  output  1  loader accepts byte this cycle
- in_data  input  8  stream byte
- im_we  output  1  instruction memory write strobe, one cycle per word
- im_waddr  output  AW  word index being written
- im_wdata  output  32  word being written
- cpu_run  output  1  high only when a load completed without error
- done  output  1  level, load completed
- err  output  1  level, load aborted

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=CNT_HI; all outputs 0; word/byte counters 0; assembly register 0.
- Transfer: a byte is taken on any clk edge where in_valid && in_ready. in_ready is a combinational decode of state only, never of in_valid.
- Stream format: count_hi, count_lo (16-bit word count N, big-endian), then N×4 data bytes, MSB first per word.
- FSM:
  - CNT_HI: in_ready=1; on transfer latch count[15:8] → CNT_LO.
  - CNT_LO: in_ready=1; on transfer form N:
    - N==0 → DONE.
    - N>NMEM → ERR.
    - else → DATA.
  - DATA: in_ready=1; shift byte into the assembly register. After the 4th byte, register im_wdata/im_waddr → WRITE.
  - WRITE: in_ready=0; im_we=1 for exactly this cycle.
    - Then increment word index.
    - If the written index equals N-1 → DONE (or CHK with the optional feature); else → DATA.
  - DONE: done=1, cpu_run=1, in_ready=0; start → CNT_HI.
  - ERR: err=1, cpu_run=0, in_ready=0; start → CNT_HI.
- Outputs and flags:
  - im_we, im_waddr and im_wdata are registered.
  - im_waddr equals the word index (0..N-1), with no wrap. Index never exceeds NMEM-1 because of the N check.
  - On entry to CNT_HI, done, err, cpu_run and the counters are cleared.
- Latency: the 4th byte of a word is accepted at edge k; im_we is high in cycle k+1. Per-word throughput is 5 cycles with in_valid held high.
- start is ignored outside DONE/ERR.
- in_valid gaps stall the FSM in its current state with no data loss.
- rst_n asserted mid-load: immediate return to the reset state and cpu_run=0. Partial memory contents are left as written.

Optional Feature:
- IM_LOADER_CHECKSUM_EN defined:
  - After the last WRITE, state CHK (in_ready=1) accepts one trailing byte.
  - If it equals the XOR of all 4N data bytes → DONE, else → ERR.
  - For N==0 the expected checksum is 8'h00; CNT_LO goes to CHK instead of DONE.
- Undefined: no CHK state, no trailing byte; WRITE of the last word goes directly to DONE.

Decomposition:
- Shared package im_loader_pkg:
  - typedef enum logic [2:0] ldr_state_t {CNT_HI, CNT_LO, DATA, WRITE, CHK, DONE, ERR}.
  - localparam BYTES_PER_WORD=4.
- One natural sub-module: im_loader_asm, a byte-to-word shift/assembler with a 2-bit byte counter and a word_ready pulse. The top keeps the FSM, word counter and checksum.

Test Plan:
- Stream 00 02 | 20 08 00 05 | AC 08 00 10, in_valid held high → im_we at addr 0 data 32'h20080005, then addr 1 data 32'hAC080010; done=1 and cpu_run=1 one cycle after the 2nd write; 12 cycles from first byte to last im_we.
- Stream 00 00 → done=1, cpu_run=1, zero im_we pulses, in_ready=0 thereafter.
- Stream 00 15 (N=21 > NMEM=20) → err=1, cpu_run=0, no im_we; a start pulse then stream 00 01 11 22 33 44 → addr 0 data 32'h11223344, done=1.
- Same two-word stream with in_valid toggling 1/0 every cycle → identical writes and addresses; in_ready=0 during each WRITE cycle; no byte dropped or duplicated.
- rst_n pulsed low after 6 bytes → outputs 0 asynchronously; a fresh stream 00 01 DE AD BE EF → single write at addr 0 data 32'hDEADBEEF.
- With IM_LOADER_CHECKSUM_EN: 00 01 01 02 03 04 04 → done=1 (XOR=04). Same stream with trailing 05 → err=1, cpu_run=0, im_we still pulsed once.
